// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, an optional skid entry and a synchronous flush.
// out_data always comes from the main entry. The skid entry only refills main.
module pipe_stage_reg #(
   parameter int          N         = 32,
   parameter logic [63:0] RST_VALUE = 64'd0,
   parameter int          SKID      = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy
);

   // state    | meaning
   // ST_EMPTY | nothing held, occupancy 0
   // ST_FULL  | main entry held, occupancy 1
   // ST_SKID  | main and skid entries held, occupancy 2 (SKID=1 only)
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   localparam logic [N-1:0] RST_V = N'(RST_VALUE);

   state_t         state_q, state_d;
   logic [N-1:0]   main_q, main_d;
   logic [N-1:0]   skid_q, skid_d;
   logic           ready_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_V;
         skid_q  <= RST_V;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != ST_SKID);
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = RST_V;
         skid_d  = RST_V;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_d  = in_data;
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (SKID != 0) begin
                  if (in_valid && out_ready) begin
                     main_d = in_data;
                  end else if (in_valid) begin
                     skid_d  = in_data;
                     state_d = ST_SKID;
                  end else if (out_ready) begin
                     state_d = ST_EMPTY;
                  end
               end else if (out_ready) begin
                  if (in_valid) main_d = in_data;
                  else          state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  main_d  = skid_q;
                  state_d = ST_FULL;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // With a skid entry, in_ready comes straight from a flop so that it has no path from out_ready.
   assign in_ready  = (SKID != 0) ? ready_q : ((state_q != ST_FULL) || out_ready);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

endmodule
